// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receiver: supported line rates.
package uart_rx_pkg;

    typedef enum int unsigned {
        BR_9600   = 9600,
        BR_19200  = 19200,
        BR_38400  = 38400,
        BR_57600  = 57600,
        BR_115200 = 115200,
        BR_230400 = 230400,
        BR_460800 = 460800,
        BR_921600 = 921600
    } uart_baud_rate_t;

endpackage

// File: rtl/rv_if.sv
// Ready/valid byte stream; TX drives valid/data, RX drives ready.
interface rv_if #(
    parameter int unsigned DW = 8
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport TX (output valid, output data, input ready);
    modport RX (input valid, input data, output ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single-entry holding register on a ready/valid port.
// Frames are never back-pressured; a full holding register drops the new byte.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned     CLOCK_FREQ = 100_000_000,
    parameter uart_baud_rate_t BAUD_RATE  = BR_115200
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    rv_if.TX     rx,
    output logic frame_err,
    output logic overrun
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / 32'(BAUD_RATE);
    localparam int unsigned SAMPLE_POINT = CLKS_PER_BIT / 2;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state, state_d;
    logic          sync1, rxs, rxs_prev;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    shreg, shreg_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

    // State register; synchronizer resets high so reset exit never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sync1    <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state    <= state_d;
            sync1    <= serial_in;
            rxs      <= sync1;
            rxs_prev <= rxs;
            cnt      <= cnt_d;
            idx      <= idx_d;
            shreg    <= shreg_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    // Next-state, bit timing and holding-register update
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        shreg_d = shreg;
        data_d  = data_q;
        valid_d = valid_q && !rx.ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        case (state)
            IDLE: begin
                if (rxs_prev && !rxs) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt == CW'(SAMPLE_POINT - 1)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shreg_d = {rxs, shreg[7:1]};
                    if (idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    // A slot freed by this cycle's handshake may be refilled at once
                    if (!rxs) begin
                        ferr_d = 1'b1;
                    end else if (!valid_q || rx.ready) begin
                        data_d  = shreg;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx.valid  = valid_q;
    assign rx.data   = data_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a default-rate instance for full-length frames and a
// 16-clocks-per-bit instance for vector tables, handshake corners and random frames.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int unsigned CPB_S    = 868;
    localparam int unsigned CPB_F    = 16;
    localparam int unsigned SP_F     = 8;
    localparam int unsigned FAST_CLK = 1_843_200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s, rst_f, line_s, line_f, ready_s, ready_f;
    logic ferr_s, ferr_f, ovr_s, ovr_f;

    rv_if #(.DW(8)) rx_s ();
    rv_if #(.DW(8)) rx_f ();
    assign rx_s.ready = ready_s;
    assign rx_f.ready = ready_f;

    uart_rx u_slow (
        .clk(clk), .rst(rst_s), .serial_in(line_s), .rx(rx_s),
        .frame_err(ferr_s), .overrun(ovr_s)
    );

    uart_rx #(.CLOCK_FREQ(FAST_CLK), .BAUD_RATE(BR_115200)) u_fast (
        .clk(clk), .rst(rst_f), .serial_in(line_f), .rx(rx_f),
        .frame_err(ferr_f), .overrun(ovr_f)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitors, sampled mid-cycle
    logic [7:0] got_s[$];
    logic [7:0] got_f[$];
    int s_ferr = 0, s_ovr = 0, s_vhi = 0, s_long = 0;
    int f_ferr = 0, f_ovr = 0, f_vlow = 0, f_long = 0;
    logic s_pf = 1'b0, s_po = 1'b0, f_pf = 1'b0, f_po = 1'b0;

    always @(negedge clk) begin
        if (!rst_s) begin
            if (rx_s.valid && ready_s) got_s.push_back(rx_s.data);
            if (rx_s.valid) s_vhi <= s_vhi + 1;
            if (ferr_s) s_ferr <= s_ferr + 1;
            if (ovr_s) s_ovr <= s_ovr + 1;
            if ((ferr_s && s_pf) || (ovr_s && s_po)) s_long <= s_long + 1;
        end
        s_pf <= ferr_s;
        s_po <= ovr_s;
    end

    always @(negedge clk) begin
        if (!rst_f) begin
            if (rx_f.valid && ready_f) got_f.push_back(rx_f.data);
            if (!rx_f.valid) f_vlow <= f_vlow + 1;
            if (ferr_f) f_ferr <= f_ferr + 1;
            if (ovr_f) f_ovr <= f_ovr + 1;
            if ((ferr_f && f_pf) || (ovr_f && f_po)) f_long <= f_long + 1;
        end
        f_pf <= ferr_f;
        f_po <= ovr_f;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, stop bit; line falls #1 after the first edge
    task automatic send_frame(input bit fast, input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        int         cpb;
        bits = {stop, d, 1'b0};
        cpb  = fast ? int'(CPB_F) : int'(CPB_S);
        tick(1);
        for (int i = 0; i < 10; i++) begin
            if (fast) line_f = bits[i];
            else      line_s = bits[i];
            tick(cpb);
        end
        if (fast) line_f = 1'b1;
        else      line_s = 1'b1;
    endtask

    function automatic logic [31:0] last_f();
        return (got_f.size() > 0) ? 32'(got_f[got_f.size()-1]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] last_s();
        return (got_s.size() > 0) ? 32'(got_s[got_s.size()-1]) : 32'hFFFF_FFFF;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       rdy;
        int         n;
        logic [7:0] last;
        int         fe;
        int         ov;
        logic       vld;
        logic [7:0] hold;
    } vec_t;

    vec_t        vecs[8];
    int          n0, fe0, ov0, v0, vl0, lg0;
    int unsigned tgt;
    int          k;
    bit          hold_mode, occ;
    logic [7:0]  held, rd;
    logic        rstop;
    logic [7:0]  exp_q[$];
    int          efe, eov;

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1'b1, 1, 8'h00, 0, 0, 1'b0, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 1, 8'hFF, 0, 0, 1'b0, 8'hFF};
        vecs[2] = '{8'h5A, 1'b0, 1'b1, 0, 8'h00, 1, 0, 1'b0, 8'hFF};
        vecs[3] = '{8'h96, 1'b1, 1'b0, 0, 8'h00, 0, 0, 1'b1, 8'h96};
        vecs[4] = '{8'h21, 1'b1, 1'b0, 0, 8'h00, 0, 1, 1'b1, 8'h96};
        vecs[5] = '{8'h34, 1'b0, 1'b0, 0, 8'h00, 1, 0, 1'b1, 8'h96};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 2, 8'h80, 0, 0, 1'b0, 8'h80};
        vecs[7] = '{8'hC7, 1'b1, 1'b1, 1, 8'hC7, 0, 0, 1'b0, 8'hC7};

        line_s = 1'b1; line_f = 1'b1; ready_s = 1'b0; ready_f = 1'b0;
        rst_s = 1'b1; rst_f = 1'b1;
        tick(4);
        check("rst_valid_s", 32'(rx_s.valid), 0);
        check("rst_data_s",  32'(rx_s.data), 0);
        check("rst_ferr_s",  32'(ferr_s), 0);
        check("rst_ovr_s",   32'(ovr_s), 0);
        check("rst_valid_f", 32'(rx_f.valid), 0);
        check("rst_data_f",  32'(rx_f.data), 0);
        rst_s = 1'b0; rst_f = 1'b0;
        tick(2 * CPB_F);
        check("idle_no_start_f", 32'(rx_f.valid), 0);

        // Full-rate frame 0xA5 with ready held high
        ready_s = 1'b1;
        n0 = got_s.size(); v0 = s_vhi; fe0 = s_ferr; ov0 = s_ovr;
        send_frame(1'b0, 8'hA5, 1'b1);
        tick(8);
        check("a5_count",   got_s.size() - n0, 1);
        check("a5_data",    last_s(), 'hA5);
        check("a5_vcycles", s_vhi - v0, 1);
        check("a5_ferr",    s_ferr - fe0, 0);
        check("a5_ovr",     s_ovr - ov0, 0);

        // 200-clock low glitch on an idle line
        n0 = got_s.size(); v0 = s_vhi; fe0 = s_ferr; ov0 = s_ovr;
        line_s = 1'b0; tick(200); line_s = 1'b1;
        tick(CPB_S);
        check("glitch_count", got_s.size() - n0, 0);
        check("glitch_valid", s_vhi - v0, 0);
        check("glitch_ferr",  s_ferr - fe0, 0);
        check("glitch_ovr",   s_ovr - ov0, 0);

        // Reset in the middle of data bit 4 of 0xFF
        n0 = got_s.size(); fe0 = s_ferr; ov0 = s_ovr;
        tgt = cyc + 1 + 5 * CPB_S + CPB_S / 2;
        fork
            send_frame(1'b0, 8'hFF, 1'b1);
            begin
                while (cyc < tgt) tick(1);
                rst_s = 1'b1;
                tick(4);
                rst_s = 1'b0;
            end
        join
        tick(4);
        check("rstmid_valid", 32'(rx_s.valid), 0);
        check("rstmid_data",  32'(rx_s.data), 0);
        check("rstmid_count", got_s.size() - n0, 0);
        check("rstmid_ferr",  s_ferr - fe0, 0);
        check("rstmid_ovr",   s_ovr - ov0, 0);
        send_frame(1'b0, 8'h12, 1'b1);
        tick(8);
        check("after_rst_count", got_s.size() - n0, 1);
        check("after_rst_data",  last_s(), 'h12);
        check("slow_long_pulse", s_long, 0);

        // Vector table on the fast instance
        for (int i = 0; i < 8; i++) begin
            n0 = got_f.size(); fe0 = f_ferr; ov0 = f_ovr;
            ready_f = vecs[i].rdy;
            send_frame(1'b1, vecs[i].d, vecs[i].stop);
            tick(2 * CPB_F);
            check($sformatf("vec%0d_count", i), got_f.size() - n0, vecs[i].n);
            if (vecs[i].n > 0) check($sformatf("vec%0d_last", i), last_f(), 32'(vecs[i].last));
            check($sformatf("vec%0d_ferr", i),  f_ferr - fe0, vecs[i].fe);
            check($sformatf("vec%0d_ovr", i),   f_ovr - ov0, vecs[i].ov);
            check($sformatf("vec%0d_valid", i), 32'(rx_f.valid), 32'(vecs[i].vld));
            check($sformatf("vec%0d_data", i),  32'(rx_f.data), 32'(vecs[i].hold));
        end

        // Back-to-back 0x3C, 0xC3 with ready low: second frame overruns
        ready_f = 1'b0;
        n0 = got_f.size(); ov0 = f_ovr;
        send_frame(1'b1, 8'h3C, 1'b1);
        send_frame(1'b1, 8'hC3, 1'b1);
        tick(2 * CPB_F);
        check("ovr_data",  32'(rx_f.data), 'h3C);
        check("ovr_valid", 32'(rx_f.valid), 1);
        check("ovr_pulse", f_ovr - ov0, 1);
        check("ovr_count", got_f.size() - n0, 0);
        ready_f = 1'b1;
        tick(3);
        check("ovr_drain_count", got_f.size() - n0, 1);
        check("ovr_drain_data",  last_f(), 'h3C);
        check("ovr_drain_valid", 32'(rx_f.valid), 0);

        // Bad stop bit on 0x55, then a good 0x81
        n0 = got_f.size(); fe0 = f_ferr;
        send_frame(1'b1, 8'h55, 1'b0);
        tick(2 * CPB_F);
        check("ferr_pulse", f_ferr - fe0, 1);
        check("ferr_valid", 32'(rx_f.valid), 0);
        check("ferr_count", got_f.size() - n0, 0);
        send_frame(1'b1, 8'h81, 1'b1);
        tick(4);
        check("post_ferr_count", got_f.size() - n0, 1);
        check("post_ferr_data",  last_f(), 'h81);

        // 0x11 held; ready pulses exactly on the stop-sample cycle of 0x22
        ready_f = 1'b0;
        send_frame(1'b1, 8'h11, 1'b1);
        tick(2 * CPB_F);
        n0 = got_f.size(); ov0 = f_ovr; vl0 = f_vlow;
        tgt = cyc + 1 + 3 + SP_F + 9 * CPB_F;
        fork
            send_frame(1'b1, 8'h22, 1'b1);
            begin
                while (cyc < tgt - 1) tick(1);
                ready_f = 1'b1;
                tick(1);
                ready_f = 1'b0;
            end
        join
        tick(CPB_F);
        check("simul_count", got_f.size() - n0, 1);
        check("simul_first", last_f(), 'h11);
        check("simul_ovr",   f_ovr - ov0, 0);
        check("simul_vlow",  f_vlow - vl0, 0);
        check("simul_valid", 32'(rx_f.valid), 1);
        check("simul_data",  32'(rx_f.data), 'h22);
        ready_f = 1'b1;
        tick(3);
        check("simul_drain", last_f(), 'h22);
        check("simul_drain_valid", 32'(rx_f.valid), 0);

        // Random frames against a holding-register occupancy model
        for (int t = 0; t < 30; t++) begin
            k = int'($urandom_range(1, 3));
            hold_mode = 1'($urandom_range(0, 1));
            occ = 1'b0; held = 8'h00;
            exp_q.delete(); efe = 0; eov = 0;
            n0 = got_f.size(); fe0 = f_ferr; ov0 = f_ovr;
            ready_f = !hold_mode;
            for (int j = 0; j < k; j++) begin
                rd    = 8'($urandom);
                rstop = ($urandom_range(0, 3) != 0);
                send_frame(1'b1, rd, rstop);
                if (!rstop)          efe++;
                else if (!hold_mode) exp_q.push_back(rd);
                else if (!occ)       begin occ = 1'b1; held = rd; end
                else                 eov++;
                tick(int'($urandom_range(0, 20)));
            end
            tick(4);
            ready_f = 1'b1;
            if (occ) exp_q.push_back(held);
            tick(4);
            check($sformatf("rand%0d_count", t), got_f.size() - n0, exp_q.size());
            for (int m = 0; m < exp_q.size(); m++)
                if (n0 + m < got_f.size())
                    check($sformatf("rand%0d_byte%0d", t, m), 32'(got_f[n0+m]), 32'(exp_q[m]));
            check($sformatf("rand%0d_ferr", t), f_ferr - fe0, efe);
            check($sformatf("rand%0d_ovr", t),  f_ovr - ov0, eov);
        end
        check("fast_long_pulse", f_long, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
